// File: rtl/cpu_pkg.sv
// Shared register-file sizing and the reference one-hot decode used by the
// destination decoder and scoreboard.
package cpu_pkg;

  localparam int REG_SEL_W = 4;
  localparam int NUM_REGS  = 1 << REG_SEL_W;

  function automatic logic [NUM_REGS-1:0] onehot_dec(input logic [REG_SEL_W-1:0] sel);
    onehot_dec      = '0;
    onehot_dec[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational SEL_W-to-2^SEL_W one-hot decoder with enable and optional
// hard-wired zero register.
module onehot_decoder
  import cpu_pkg::*;
#(
  parameter int SEL_W    = REG_SEL_W,
  parameter bit ZERO_REG = 1'b1,
  localparam int NUM_OUT = 1 << SEL_W
) (
  input  logic [SEL_W-1:0]   sel,
  input  logic               en,
  output logic [NUM_OUT-1:0] onehot
);

  logic [NUM_OUT-1:0] raw;

  generate
    if (SEL_W == REG_SEL_W) begin : g_pkg
      assign raw = onehot_dec(sel);
    end else begin : g_gen
      for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_bit
        assign raw[gi] = (sel == SEL_W'(gi));
      end
    end
  endgenerate

  // The enable gates the whole word so a stale select can never leak through.
  always_comb begin
    onehot = en ? raw : '0;
    if (ZERO_REG) onehot[0] = 1'b0;
  end

endmodule

// File: rtl/dest_decode_scoreboard.sv
// Destination decoder plus register busy scoreboard: tracks in-flight writes,
// raises stall on RAW/WAW hazards and drives the register-file write enable.
module dest_decode_scoreboard
  import cpu_pkg::*;
#(
  parameter int SEL_W    = REG_SEL_W,
  parameter bit ZERO_REG = 1'b1,
  parameter bit OUT_REG  = 1'b1,
  localparam int NUM_OUT = 1 << SEL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_en,
  input  logic [SEL_W-1:0]   issue_sel,
  input  logic               rd_a_en,
  input  logic [SEL_W-1:0]   rd_a_sel,
  input  logic               rd_b_en,
  input  logic [SEL_W-1:0]   rd_b_sel,
  input  logic               wb_en,
  input  logic [SEL_W-1:0]   wb_sel,
  output logic               issue_ack,
  output logic               stall,
  output logic [NUM_OUT-1:0] wb_onehot,
  output logic [NUM_OUT-1:0] busy,
  output logic [SEL_W:0]     pending_cnt
);

  logic [NUM_OUT-1:0] busy_q, busy_d;
  logic [SEL_W:0]     pending_cnt_q, pending_cnt_d;
  logic [NUM_OUT-1:0] set_m, clr_m;
  logic               busy_a, busy_b, busy_i;

  // A writeback landing this cycle retires the register, so it no longer blocks.
  assign busy_a = busy_q[rd_a_sel]  & ~(wb_en & (wb_sel == rd_a_sel));
  assign busy_b = busy_q[rd_b_sel]  & ~(wb_en & (wb_sel == rd_b_sel));
  assign busy_i = busy_q[issue_sel] & ~(wb_en & (wb_sel == issue_sel));

  assign stall     = (rd_a_en & busy_a) | (rd_b_en & busy_b) | (issue_en & busy_i);
  assign issue_ack = issue_en & ~stall;

  onehot_decoder #(.SEL_W(SEL_W), .ZERO_REG(ZERO_REG)) u_issue_dec (
    .sel    (issue_sel),
    .en     (issue_ack),
    .onehot (set_m)
  );

  onehot_decoder #(.SEL_W(SEL_W), .ZERO_REG(ZERO_REG)) u_wb_dec (
    .sel    (wb_sel),
    .en     (wb_en),
    .onehot (clr_m)
  );

  always_comb begin
    busy_d        = (busy_q & ~clr_m) | set_m;
    pending_cnt_d = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      pending_cnt_d = pending_cnt_d + (SEL_W + 1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q        <= '0;
      pending_cnt_q <= '0;
    end else begin
      busy_q        <= busy_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  generate
    if (OUT_REG) begin : g_wb_reg
      logic [NUM_OUT-1:0] wb_onehot_q;
      always_ff @(posedge clk) begin
        if (reset) wb_onehot_q <= '0;
        else       wb_onehot_q <= clr_m;
      end
      assign wb_onehot = wb_onehot_q;
    end else begin : g_wb_comb
      assign wb_onehot = clr_m;
    end
  endgenerate

  assign busy        = busy_q;
  assign pending_cnt = pending_cnt_q;

endmodule

// File: tb/tb_dest_decode_scoreboard.sv
// Directed vector bench for dest_decode_scoreboard: default configuration plus
// a SEL_W=5 combinational-writeback instance.
module tb_dest_decode_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_en, rd_a_en, rd_b_en, wb_en;
  logic [3:0]  issue_sel, rd_a_sel, rd_b_sel, wb_sel;
  logic        issue_ack, stall;
  logic [15:0] wb_onehot, busy;
  logic [4:0]  pending_cnt;

  logic        d2_issue_en, d2_rd_a_en, d2_rd_b_en, d2_wb_en;
  logic [4:0]  d2_issue_sel, d2_rd_a_sel, d2_rd_b_sel, d2_wb_sel;
  logic        d2_issue_ack, d2_stall;
  logic [31:0] d2_wb_onehot, d2_busy;
  logic [5:0]  d2_pending_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dest_decode_scoreboard dut (
    .clk(clk), .reset(reset),
    .issue_en(issue_en), .issue_sel(issue_sel),
    .rd_a_en(rd_a_en), .rd_a_sel(rd_a_sel),
    .rd_b_en(rd_b_en), .rd_b_sel(rd_b_sel),
    .wb_en(wb_en), .wb_sel(wb_sel),
    .issue_ack(issue_ack), .stall(stall),
    .wb_onehot(wb_onehot), .busy(busy), .pending_cnt(pending_cnt)
  );

  dest_decode_scoreboard #(.SEL_W(5), .ZERO_REG(1'b1), .OUT_REG(1'b0)) dut2 (
    .clk(clk), .reset(reset),
    .issue_en(d2_issue_en), .issue_sel(d2_issue_sel),
    .rd_a_en(d2_rd_a_en), .rd_a_sel(d2_rd_a_sel),
    .rd_b_en(d2_rd_b_en), .rd_b_sel(d2_rd_b_sel),
    .wb_en(d2_wb_en), .wb_sel(d2_wb_sel),
    .issue_ack(d2_issue_ack), .stall(d2_stall),
    .wb_onehot(d2_wb_onehot), .busy(d2_busy), .pending_cnt(d2_pending_cnt)
  );

  typedef struct {
    logic        rst;
    logic        ie;  logic [3:0] is;
    logic        ae;  logic [3:0] as;
    logic        be;  logic [3:0] bs;
    logic        we;  logic [3:0] ws;
    logic        x_ack;
    logic        x_stall;
    logic [15:0] x_busy;
    logic [4:0]  x_cnt;
    logic [15:0] x_wb;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic rst, input logic ie, input logic [3:0] is,
                              input logic ae, input logic [3:0] as,
                              input logic be, input logic [3:0] bs,
                              input logic we, input logic [3:0] ws,
                              input logic x_ack, input logic x_stall,
                              input logic [15:0] x_busy, input logic [4:0] x_cnt,
                              input logic [15:0] x_wb);
    vec_t v;
    v.rst = rst; v.ie = ie; v.is = is; v.ae = ae; v.as = as; v.be = be; v.bs = bs;
    v.we = we; v.ws = ws; v.x_ack = x_ack; v.x_stall = x_stall;
    v.x_busy = x_busy; v.x_cnt = x_cnt; v.x_wb = x_wb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ie, input logic [3:0] is, input logic ae, input logic [3:0] as,
                       input logic be, input logic [3:0] bs, input logic we, input logic [3:0] ws);
    issue_en = ie; issue_sel = is; rd_a_en = ae; rd_a_sel = as;
    rd_b_en = be; rd_b_sel = bs; wb_en = we; wb_sel = ws;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    d2_issue_en = 0; d2_issue_sel = 0; d2_rd_a_en = 0; d2_rd_a_sel = 0;
    d2_rd_b_en = 0; d2_rd_b_sel = 0; d2_wb_en = 0; d2_wb_sel = 0;

    //             rst ie is    ae as    be bs    we ws    ack stl busy      cnt wb
    vecs[0]  = mk(1, 1, 4'd5, 0, 4'd0, 0, 4'd0, 0, 4'd0, 1, 0, 16'h0000, 0, 16'h0000);
    vecs[1]  = mk(0, 1, 4'd3, 0, 4'd0, 0, 4'd0, 0, 4'd0, 1, 0, 16'h0008, 1, 16'h0000);
    vecs[2]  = mk(0, 1, 4'd4, 1, 4'd3, 0, 4'd0, 0, 4'd0, 0, 1, 16'h0008, 1, 16'h0000);
    vecs[3]  = mk(0, 1, 4'd4, 1, 4'd3, 0, 4'd0, 1, 4'd3, 1, 0, 16'h0010, 1, 16'h0008);
    vecs[4]  = mk(0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 16'h0010, 1, 16'h0000);
    vecs[5]  = mk(0, 1, 4'd7, 0, 4'd0, 0, 4'd0, 0, 4'd0, 1, 0, 16'h0090, 2, 16'h0000);
    vecs[6]  = mk(0, 1, 4'd7, 0, 4'd0, 0, 4'd0, 1, 4'd7, 1, 0, 16'h0090, 2, 16'h0080);
    vecs[7]  = mk(0, 1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 1, 0, 16'h0090, 2, 16'h0000);
    vecs[8]  = mk(0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 1, 4'd0, 0, 0, 16'h0090, 2, 16'h0000);
    vecs[9]  = mk(0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 1, 4'd5, 0, 0, 16'h0090, 2, 16'h0020);
    vecs[10] = mk(0, 1, 4'd9, 0, 4'd0, 1, 4'd4, 0, 4'd0, 0, 1, 16'h0090, 2, 16'h0000);
    vecs[11] = mk(0, 1, 4'd9, 0, 4'd0, 0, 4'd4, 0, 4'd0, 1, 0, 16'h0290, 3, 16'h0000);
    vecs[12] = mk(0, 1, 4'd2, 1, 4'd9, 1, 4'd7, 1, 4'd9, 0, 1, 16'h0090, 2, 16'h0200);
    vecs[13] = mk(1, 1, 4'd2, 0, 4'd0, 0, 4'd0, 1, 4'd4, 1, 0, 16'h0000, 0, 16'h0000);

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      reset = vecs[i].rst;
      drive(vecs[i].ie, vecs[i].is, vecs[i].ae, vecs[i].as,
            vecs[i].be, vecs[i].bs, vecs[i].we, vecs[i].ws);
      #2;
      check($sformatf("v%0d issue_ack", i), 32'(issue_ack), 32'(vecs[i].x_ack));
      check($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].x_stall));
      @(posedge clk); #1;
      check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].x_busy));
      check($sformatf("v%0d pending_cnt", i), 32'(pending_cnt), 32'(vecs[i].x_cnt));
      check($sformatf("v%0d wb_onehot", i), 32'(wb_onehot), 32'(vecs[i].x_wb));
      $display("vec %0d: ack=%0d stall=%0d busy=%h cnt=%0d wb=%h",
               i, issue_ack, stall, busy, pending_cnt, wb_onehot);
    end
    reset = 1'b0;

    // Fill every writable register, one issue per cycle.
    for (int r = 1; r < 16; r++) begin
      drive(1'b1, 4'(r), 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
      #2;
      check($sformatf("fill%0d issue_ack", r), 32'(issue_ack), 32'd1);
      @(posedge clk); #1;
      $display("fill %0d: busy=%h cnt=%0d", r, busy, pending_cnt);
    end
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    #2;
    check("full busy", 32'(busy), 32'h0000_FFFE);
    check("full pending_cnt", 32'(pending_cnt), 32'd15);

    drive(1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    #2;
    check("waw issue_ack", 32'(issue_ack), 32'd0);
    check("waw stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    check("waw busy", 32'(busy), 32'h0000_FFFE);
    $display("waw 9: ack=%0d stall=%0d busy=%h", issue_ack, stall, busy);

    drive(1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd9);
    #2;
    check("waw+wb issue_ack", 32'(issue_ack), 32'd1);
    @(posedge clk); #1;
    check("waw+wb busy", 32'(busy), 32'h0000_FFFE);
    check("waw+wb pending_cnt", 32'(pending_cnt), 32'd15);
    check("waw+wb wb_onehot", 32'(wb_onehot), 32'h0000_0200);
    $display("issue+wb 9: busy=%h cnt=%0d wb=%h", busy, pending_cnt, wb_onehot);
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);

    // Wide instance with combinational write enable.
    d2_wb_en = 1'b1; d2_wb_sel = 5'd31;
    #2;
    check("d2 wb_onehot 31", d2_wb_onehot, 32'h8000_0000);
    $display("d2 wb 31: wb=%h", d2_wb_onehot);
    d2_wb_en = 1'b0;
    #1;
    check("d2 wb_onehot off", d2_wb_onehot, 32'h0000_0000);
    d2_issue_en = 1'b1; d2_issue_sel = 5'd31;
    #1;
    check("d2 issue_ack", 32'(d2_issue_ack), 32'd1);
    @(posedge clk); #1;
    check("d2 busy", d2_busy, 32'h8000_0000);
    check("d2 pending_cnt", 32'(d2_pending_cnt), 32'd1);
    d2_issue_en = 1'b0; d2_rd_a_en = 1'b1; d2_rd_a_sel = 5'd31;
    #1;
    check("d2 raw stall", 32'(d2_stall), 32'd1);
    $display("d2 raw 31: stall=%0d busy=%h", d2_stall, d2_busy);
    d2_rd_a_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
